// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, reads imem, and queues {pc, instr} pairs for decode.
// Optional same-cycle head bypass of an empty queue is enabled by defining IFQ_BYPASS_EN.
module fetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ifq_valid,
  output logic [XLEN-1:0] ifq_pc,
  output logic [31:0]     ifq_instr,
  input  logic            ifq_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  st_pc    [DEPTH];
  logic [31:0]      st_instr [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic byp;
  logic pop;
  logic fetch;
  logic wr_en;
  logic rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign imem_addr = {2'b00, pc_q[XLEN-1:2]};
  assign full      = (count == CNT_W'(DEPTH));

`ifdef IFQ_BYPASS_EN
  // Gated by reset_n so the head reads as empty while reset is held.
  assign byp = reset_n & (count == '0) & ~redirect_valid;
`else
  assign byp = 1'b0;
`endif

  assign ifq_valid = (count != '0) | byp;
  assign ifq_pc    = byp ? pc_q       : st_pc[rd_ptr];
  assign ifq_instr = byp ? imem_instr : st_instr[rd_ptr];

  // A full queue always has a valid head, so "full and popping" reduces to full & ready.
  assign pop   = ifq_valid & ifq_ready & ~redirect_valid;
  assign fetch = ~redirect_valid & (~full | ifq_ready);
  assign wr_en = fetch & ~(byp & ifq_ready);
  assign rd_en = pop & ~byp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        st_pc[i]    <= '0;
        st_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc_q   <= {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        st_pc[wr_ptr]    <= pc_q;
        st_instr[wr_ptr] <= imem_instr;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (fetch) pc_q <= pc_q + XLEN'(4);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: queue-based reference model plus a small XLEN=8 wrap instance.
module tb_fetch_queue;

  localparam int          XLEN  = 64;
  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h0;
`ifdef IFQ_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ifq_valid;
  logic [63:0] ifq_pc;
  logic [31:0] ifq_instr;
  logic        ifq_ready;

  logic        s_rst_n;
  logic [7:0]  s_addr;
  logic [31:0] s_instr;
  logic        s_valid;
  logic [7:0]  s_pc;
  logic [31:0] s_ifq_instr;

  int          n_cmp = 0;
  int          n_bad = 0;
  ent_t        sb[$];
  int          mcount;
  logic [63:0] mpc;
  logic        exp_valid;
  logic [63:0] exp_addr;
  bit          run = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] waddr);
    return waddr[31:0] + 32'h100;
  endfunction

  assign imem_instr = mem_word(imem_addr);
  assign s_instr    = mem_word({56'h0, s_addr});

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifq_valid(ifq_valid), .ifq_pc(ifq_pc), .ifq_instr(ifq_instr), .ifq_ready(ifq_ready)
  );

  fetch_queue #(.XLEN(8), .DEPTH(3), .RESET_PC(8'hF8)) u_small (
    .clk(clk), .reset_n(s_rst_n), .imem_addr(s_addr), .imem_instr(s_instr),
    .redirect_valid(1'b0), .redirect_pc(8'h00),
    .ifq_valid(s_valid), .ifq_pc(s_pc), .ifq_instr(s_ifq_instr), .ifq_ready(1'b1)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference step for the upcoming rising edge, issued right after a falling edge.
  task automatic step(input bit rdy, input bit redir, input logic [63:0] tgt);
    bit   pop, fetch;
    ent_t e;
    ifq_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    exp_addr       = {2'b00, mpc[63:2]};
    exp_valid      = (mcount != 0) || (BYP == 1 && !redir);
    if (redir) begin
      sb.delete();
      mcount = 0;
      mpc    = {tgt[63:2], 2'b00};
    end else begin
      pop   = exp_valid && rdy;
      fetch = (mcount < DEPTH) || pop;
      if (fetch) begin
        e.pc    = mpc;
        e.instr = mem_word(mpc >> 2);
        sb.push_back(e);
        mpc = mpc + 64'd4;
      end
      mcount = mcount + int'(fetch) - int'(pop);
    end
  endtask

  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      #1;
      if (run && reset_n) begin
        check("valid", {63'h0, ifq_valid}, {63'h0, exp_valid});
        check("imem_addr", imem_addr, exp_addr);
        if (ifq_valid && ifq_ready && !redirect_valid) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL head: popped pc %h but expected queue is empty", ifq_pc);
          end else begin
            e = sb.pop_front();
            check("head_pc", ifq_pc, e.pc);
            check("head_instr", {32'h0, ifq_instr}, {32'h0, e.instr});
          end
        end
      end
    end
  end

  initial begin : small_wrap
    logic [7:0] a, h;
    s_rst_n = 1'b0;
    #12;
    check("small_rst_addr", {56'h0, s_addr}, 64'h3E);
    check("small_rst_valid", {63'h0, s_valid}, 64'h0);
    @(negedge clk);
    s_rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      a = 8'hF8 + 8'(4 * k);
      h = 8'hF8 + 8'(4 * (k - 1 + BYP));
      check("small_addr", {56'h0, s_addr}, {58'h0, a[7:2]});
      check("small_valid", {63'h0, s_valid}, 64'h1);
      check("small_pc", {56'h0, s_pc}, {56'h0, h});
      check("small_instr", {32'h0, s_ifq_instr}, {32'h0, mem_word({58'h0, h[7:2]})});
    end
  end

  initial begin : driver
    bit          rdy, redir, rst;
    logic [63:0] tgt;
    reset_n        = 1'b0;
    ifq_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mcount         = 0;
    mpc            = RPC;
    #12;
    check("rst_valid", {63'h0, ifq_valid}, 64'h0);
    check("rst_pc", ifq_pc, 64'h0);
    check("rst_instr", {32'h0, ifq_instr}, 64'h0);
    check("rst_addr", imem_addr, RPC >> 2);
    @(negedge clk);
    reset_n = 1'b1;
    run     = 1;
    for (int c = 0; c < 1500; c++) begin
      rdy   = 1'b1;
      redir = 1'b0;
      tgt   = '0;
      rst   = 1'b0;
      if (c >= 8 && c < 18) rdy = 1'b0;
      else if (c == 28) begin
        redir = 1'b1;
        tgt   = 64'h203;
      end else if (c == 36 || c == 37) rdy = 1'b0;
      else if (c == 38) rst = 1'b1;
      else if (c > 38) begin
        rdy   = (c >= 600 && c < 700) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        redir = ($urandom_range(0, 19) == 0);
        tgt   = {$urandom, $urandom};
        rst   = ($urandom_range(0, 299) == 0);
      end
      step(rdy, redir, tgt);
      if (rst) begin
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", {63'h0, ifq_valid}, 64'h0);
        check("midrst_pc", ifq_pc, 64'h0);
        check("midrst_instr", {32'h0, ifq_instr}, 64'h0);
        check("midrst_addr", imem_addr, RPC >> 2);
        sb.delete();
        mcount = 0;
        mpc    = RPC;
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    run = 0;
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage for the pipelined RISC-V core. It replaces the single-cycle PC register, PC+4 adder and branch multiplexer with a fetch block that holds its own PC, reads the instruction memory, and buffers fetched {pc, instruction} pairs in a DEPTH-entry FIFO. The FIFO feeds decode through a valid/ready handshake. Branch and jump redirects from execute flush the FIFO and restart fetch at the target.

## Interface
Parameters:
- XLEN, 64, PC and address width.
- DEPTH, 4, number of FIFO entries; any value ≥ 2, not necessarily a power of two.
- RESET_PC, 0, byte address fetched first after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_addr  out  XLEN  word address into instruction memory, equal to {2'b00, pc[XLEN-1:2]}.
- imem_instr  in  32  instruction at imem_addr; combinational, same cycle.
- redirect_valid  in  1  single-cycle pulse that flushes the FIFO and loads a new PC.
- redirect_pc  in  XLEN  target byte address; bits [1:0] are ignored and forced to 0.
- ifq_valid  out  1  FIFO head holds a valid entry.
- ifq_pc  out  XLEN  byte PC of the head entry.
- ifq_instr  out  32  instruction of the head entry.
- ifq_ready  in  1  decode accepts the head this cycle.

## Operation
- State: pc register, DEPTH×(XLEN+32) storage, rd_ptr, wr_ptr, count. Pointer width is clog2(DEPTH); count width is clog2(DEPTH+1).
- pop = ifq_valid & ifq_ready & ~redirect_valid.
- fetch = ~redirect_valid & (count < DEPTH | pop). A full FIFO that is popping in the same cycle still accepts a fetch.
- On fetch:
  - write {pc, imem_instr} at wr_ptr;
  - wr_ptr advances with wrap from DEPTH-1 to 0;
  - pc <= pc + 4, modulo 2^XLEN.
- On pop: rd_ptr advances with wrap.
- count <= count + fetch - pop.
- On redirect_valid:
  - count, rd_ptr and wr_ptr <= 0;
  - pc <= {redirect_pc[XLEN-1:2], 2'b00};
  - no fetch and no pop occur in that cycle, whatever ifq_ready is.
- The head outputs come from storage[rd_ptr]; ifq_valid = (count != 0).
- Simultaneous events:
  - redirect beats both fetch and pop;
  - pop and fetch in the same cycle leave count unchanged;
  - reset beats everything.
- Values are never checked for legality. Illegal opcodes pass through unchanged.

## Timing
- Reset (asynchronous, any time, including mid-stream):
  - pc = RESET_PC, count = 0, both pointers 0, all storage 0;
  - ifq_valid = 0, ifq_pc = 0, ifq_instr = 0;
  - imem_addr = RESET_PC >> 2.
- Reset release: the first fetch happens on the first rising edge with reset_n high.
- Fetch-to-head latency with an empty FIFO: 1 cycle. The instruction fetched at edge N is visible at the head after edge N.
- Redirect-to-head latency: 2 cycles. The redirect is sampled at edge N, the target is fetched at edge N+1, and it is valid after edge N+1.
- Steady state: with ifq_ready held high, throughput is one instruction per cycle.
- Backpressure: while ifq_ready is low, fetch stalls once count == DEPTH. The head and imem_addr stay stable during the stall.

## Configuration
- IFQ_BYPASS_EN defined:
  - When count == 0 and fetch is asserted, the head outputs show {pc, imem_instr} combinationally and ifq_valid = 1 in the same cycle.
  - If ifq_ready is also high, the entry is consumed and is not written into the FIFO; count stays 0.
  - Fetch-to-head latency becomes 0 and redirect-to-head latency becomes 1.
- IFQ_BYPASS_EN undefined:
  - Outputs come only from registered storage; the latencies are the ones given under Timing.

## Test plan
- Reset release, RESET_PC=0, ifq_ready=1 throughout, imem word k = k+0x100 → the head presents pc 0,4,8,… with instr 0x100,0x101,… on consecutive cycles; ifq_valid first rises 1 cycle after release.
- ifq_ready=0 for 10 cycles, DEPTH=4 → count saturates at 4 and imem_addr holds at 4. Raising ready then yields pc 0,4,8,12,16 with no gap and no duplicate.
- FIFO full with ifq_ready=1 → pop and fetch occur in the same cycle, count stays 4, and the pointers wrap 3→0 with the data order preserved.
- redirect_valid with redirect_pc=0x203 while 3 entries are queued and ifq_ready=1 → the next cycle shows ifq_valid=0 and imem_addr=0x80; pc 0x200 reaches the head 2 cycles after the redirect, and no old entry ever appears.
- reset_n asserted mid-cycle with 2 entries queued → ifq_valid drops to 0 immediately, with no clock edge needed, and fetch restarts at RESET_PC after release.
- pc=2^XLEN-4 (XLEN=8 instance) → the following fetch address wraps to 0.
